// File: rtl/johnson_counter_param_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : johnson_counter_param_if
// Brief    : Control/status bundle for the parametrised Johnson/ring counter.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface johnson_counter_param_if #(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2*WIDTH)
);
  logic             en;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic [PW-1:0]    phase;
  logic             wrap;
  logic             illegal;

  // Controller side: drives the strobes, observes the counter
  modport master (
    output en, dir, mode, load, load_val,
    input  out, phase, wrap, illegal
  );

  // Counter side
  modport slave (
    input  en, dir, mode, load, load_val,
    output out, phase, wrap, illegal
  );
endinterface
`default_nettype wire

// File: rtl/johnson_counter_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : johnson_counter_param
// Brief    : WIDTH-bit Johnson / ring sequencer with enable, direction,
//            parallel load, illegal-state self-correction, phase decode
//            and wrap pulse. WIDTH must be at least 2.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module johnson_counter_param #(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  johnson_counter_param_if.slave        bus
);

  localparam logic [WIDTH-1:0] ZERO      = '0;
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    LAST_JOHN = PW'(2*WIDTH-1);
  localparam logic [PW-1:0]    LAST_RING = PW'(WIDTH-1);

  logic [WIDTH-1:0] out_q;
  logic             wrap_q;
  logic             illegal_q;

  logic [WIDTH-1:0] inv;
  logic             john_legal;
  logic             ring_legal;
  logic             legal;
  logic [PW-1:0]    ones;
  logic [PW-1:0]    ring_idx;
  logic [PW-1:0]    phase;
  logic [PW-1:0]    last_phase;
  logic [WIDTH-1:0] next_step;
  logic             step_wraps;

  // Legality: Johnson codes are a run of ones anchored at bit 0 or at the MSB
  // (all-zero and all-one fall in both); ring codes are one-hot or the seed 0.
  assign inv        = ~out_q;
  assign john_legal = ((out_q & (out_q + ONE)) == ZERO) || ((inv & (inv + ONE)) == ZERO);
  assign ring_legal = ((out_q & (out_q - ONE)) == ZERO);
  assign legal      = bus.mode ? ring_legal : john_legal;

  // Popcount and set-bit index feed the phase decode
  always_comb begin
    ones     = '0;
    ring_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + PW'(out_q[i]);
      if (out_q[i]) ring_idx = PW'(i);
    end
  end

  // Phase index of the current code under the currently selected mode
  always_comb begin
    phase = '0;
    if (legal) begin
      if (bus.mode)               phase = ring_idx;
      else if (!out_q[WIDTH-1])   phase = ones;
      else                        phase = PW'(WIDTH) + (PW'(WIDTH) - ones);
    end
  end

  // Next code for an enabled step in the selected mode and direction
  always_comb begin
    next_step = out_q;
    case ({bus.mode, bus.dir})
      2'b00:   next_step = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
      2'b01:   next_step = {~out_q[0], out_q[WIDTH-1:1]};
      2'b10:   next_step = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
      default: next_step = {out_q[0], out_q[WIDTH-1:1]};
    endcase
  end

  // A step wraps when it leaves the last phase forward or phase 0 in reverse
  assign last_phase = bus.mode ? LAST_RING : LAST_JOHN;
  assign step_wraps = bus.dir ? (phase == '0) : (phase == last_phase);

  // Counter state with correction > load > step > hold priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      wrap_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      wrap_q    <= 1'b0;
      illegal_q <= 1'b0;
      if (!legal) begin
        out_q     <= bus.mode ? ONE : ZERO;
        illegal_q <= 1'b1;
      end else if (bus.load) begin
        out_q <= bus.load_val;
      end else if (bus.en) begin
        if (bus.mode && (out_q == ZERO)) begin
          // Ring seed: the empty register is primed with a single token
          out_q <= ONE;
        end else begin
          out_q  <= next_step;
          wrap_q <= step_wraps;
        end
      end
    end
  end

  assign bus.out     = out_q;
  assign bus.phase   = phase;
  assign bus.wrap    = wrap_q;
  assign bus.illegal = illegal_q;

endmodule
`default_nettype wire
